tlp_mwr_to_axi: RTL and testbench
=================================

Name: tlp_mwr_to_axi

Overview:
- Downstream consumer of the write-request output of the TLP read/write demultiplexer.
- Takes Memory Write TLPs (4DW header plus 8DW payload beats, sop/eop/valid/ready) and turns each one into a single AXI4 INCR write burst (AW, W, B) on a 256-bit AXI master port.
- Supports one outstanding write.
- Drops malformed or non-MWr traffic and reports completion and error events as pulses.

Parameters:
- DOUBLE_WORD, 32, DW width in bits.
- HEADER_SIZE, 4*DOUBLE_WORD, TLP header width.
- PAYLOAD_SIZE, 8*DOUBLE_WORD, payload beat width; also the AXI data width.
- AXI_ID, 4'h0, constant value driven on m_axi_awid.
- ID_WIDTH, 4, AXI ID width.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  PAYLOAD_SIZE  payload beat; DW i occupies bits [32i+31:32i], already lane-aligned to addr[4:2]
- in_hdr  in  HEADER_SIZE  TLP header; valid on sop beat
- in_sop  in  1  first beat of TLP
- in_eop  in  1  last beat of TLP
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- m_axi_awid  out  ID_WIDTH  = AXI_ID
- m_axi_awaddr  out  64  burst address, bits[4:0]=0
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant 3'b101
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  PAYLOAD_SIZE
- m_axi_wstrb  out  PAYLOAD_SIZE/8
- m_axi_wlast  out  1
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bid  in  ID_WIDTH  ignored
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- enable  in  1  0 blocks acceptance of new TLPs
- wr_done  out  1  one-cycle pulse on B handshake
- wr_err  out  1  one-cycle pulse: bresp!=0 or length mismatch, asserted with wr_done
- tlp_drop  out  1  one-cycle pulse when a dropped TLP's last beat is consumed

Behaviour:
- Header fields:
  - fmt/type = hdr[127:120]; MWr = 8'h60.
  - len = hdr[105:96]; 0 means 1024.
  - last BE = hdr[71:68]; first BE = hdr[67:64].
  - addr = {hdr[63:32], hdr[31:2], 2'b00}.
- Arithmetic, done on 11-bit widths:
  - off = addr[4:2].
  - beats = (off + len + 7) >> 3, range 1..129.
  - awlen = beats-1.
  - last lane = (off+len-1) mod 8.
  - awaddr = {addr[63:5], 5'b0}.
- Strobes per beat:
  - Lanes below off on beat 0 get 0.
  - Lanes above the last lane on the final beat get 0.
  - The first-DW lane gets the first BE; the last-DW lane gets the last BE, or the first BE when len==1.
  - All other lanes get 4'hF.
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - in_ready, awvalid, wvalid, wlast, bready, wr_done, wr_err and tlp_drop all go to 0.
  - awaddr, awlen, wstrb and the beat counter go to 0.
  - Reset mid-burst abandons the burst; the AXI slave must be reset alongside.
- IDLE:
  - in_ready=0; the sop beat is held by the upstream.
  - If enable & in_valid & in_sop & fmt/type==8'h60: latch header fields, set awvalid=1 next cycle, go to ADDR.
  - If in_valid and (!in_sop or fmt/type!=8'h60): go to DROP. This is regardless of enable.
- ADDR:
  - Hold awvalid until awready.
  - On handshake: awvalid=0, beat counter=0, go to DATA.
  - AW always completes before any W beat.
- DATA:
  - W is a combinational pass-through: wvalid=in_valid, wdata=in_data, in_ready=wready.
  - wlast=(counter==awlen).
  - The counter increments on each W handshake.
- Early eop (in_eop on a beat with counter<awlen):
  - After that beat, in_ready=0.
  - The remaining beats are issued with wvalid=1, wdata=0, wstrb=0, wlast only on the final beat.
  - Error is latched.
- Missing eop at the last W beat:
  - After the wlast handshake, go to TRAIL.
  - TRAIL holds in_ready=1 and discards beats through eop, then goes to RESP.
  - Error is latched.
- RESP:
  - bready=1.
  - On bvalid: wr_done=1, wr_err=(bresp!=0)|latched error, clear the latch, go to IDLE.
  - Next TLP is accepted no earlier than the cycle after the B handshake.
- DROP:
  - in_ready=1; consume beats until in_valid&in_eop.
  - Then tlp_drop=1 and go to IDLE.
  - A single beat with sop=eop=1 drops in one cycle.
- TLPs do not cross 4KB, per PCIe rules, so no burst splitting is performed.
- enable=0 only gates the IDLE→ADDR transition. A TLP already in progress completes.

Test Plan:
- Single-DW MWr, addr 0x1000_0004, len=1, firstBE=F → awaddr 0x1000_0000, awlen 0; one W beat, wstrb 0x0000_00F0, wlast=1; wr_done pulse, wr_err=0.
- addr 0x2000_001C, len=10, firstBE=F, lastBE=3, 3 beats → awlen 2; wstrb 0xF000_0000, 0xFFFF_FFFF, 0x0000_0003; wlast on beat 3.
- MRd header (8'h20), 2 beats → in_ready=1 in DROP, tlp_drop pulse on beat 2, no AW; a following MWr is processed normally.
- len=16, off=0, eop on beat 1 → beat 2 issued with wstrb 0, wlast=1; wr_err=1 with wr_done.
- Single-beat MWr, bresp=2'b10 → wr_err=1; wready held low for 5 cycles → in_ready low for the same 5 cycles, data unchanged; enable=0 in IDLE → awvalid stays 0.
- Reset asserted during DATA → next cycle all valids 0, state IDLE; a fresh MWr completes correctly.

Source files
------------

// File: rtl/tlp_mwr_to_axi.sv
// tlp_mwr_to_axi
//   Converts one PCIe Memory Write TLP (4DW header, 8DW payload beats) into a
//   single AXI4 INCR write burst on a 256-bit master port. Only one write is
//   in flight at a time. Non-MWr or malformed traffic is consumed and dropped.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_*                  TLP beat stream (data/hdr/sop/eop/valid/ready)
//   m_axi_aw*/w*/b*       AXI4 write master (AW, W, B channels)
//   enable                0 holds off acceptance of new TLPs
//   wr_done, wr_err       pulse on B handshake; error when bresp!=0 or length
//                         mismatch between TLP eop and the computed burst
//   tlp_drop              pulse when the last beat of a dropped TLP is consumed
module tlp_mwr_to_axi #(
   parameter int DOUBLE_WORD  = 32,
   parameter int HEADER_SIZE  = 4*DOUBLE_WORD,
   parameter int PAYLOAD_SIZE = 8*DOUBLE_WORD,
   parameter int ID_WIDTH     = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID = '0
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PAYLOAD_SIZE-1:0]   in_data,
   input  logic [HEADER_SIZE-1:0]    in_hdr,
   input  logic                      in_sop,
   input  logic                      in_eop,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [ID_WIDTH-1:0]       m_axi_awid,
   output logic [63:0]               m_axi_awaddr,
   output logic [7:0]                m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic [1:0]                m_axi_awburst,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [PAYLOAD_SIZE-1:0]   m_axi_wdata,
   output logic [PAYLOAD_SIZE/8-1:0] m_axi_wstrb,
   output logic                      m_axi_wlast,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [ID_WIDTH-1:0]       m_axi_bid,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   input  logic                      enable,
   output logic                      wr_done,
   output logic                      wr_err,
   output logic                      tlp_drop
);

   localparam int LANES = PAYLOAD_SIZE/DOUBLE_WORD;
   localparam int BE_W  = DOUBLE_WORD/8;

   // PAD: early eop, remaining beats are zero-filled with zero strobes.
   // TRAIL: burst complete but TLP still has beats; discard through eop.
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_PAD, S_TRAIL, S_RESP, S_DROP
   } state_t;

   state_t state, state_n;

   logic [7:0]      cnt;
   logic [2:0]      off, last_lane;
   logic [BE_W-1:0] first_be, last_be;
   logic            len1, err;

   // header decode, all on 11 bits so len=1024 and off+len+7 fit
   logic        is_mwr;
   logic [10:0] len11, span, sum11, awlen11, last11;

   assign is_mwr  = (in_hdr[127:120] == 8'h60);
   assign len11   = (in_hdr[105:96] == 10'd0) ? 11'd1024 : {1'b0, in_hdr[105:96]};
   assign span    = {8'd0, in_hdr[4:2]} + len11;
   assign sum11   = span + 11'd7;
   assign awlen11 = {3'd0, sum11[10:3]} - 11'd1;
   assign last11  = span - 11'd1;

   logic unused_ok;
   assign unused_ok = ^{m_axi_bid, in_hdr[119:106], in_hdr[95:72], in_hdr[1:0],
                        sum11[2:0], awlen11[10:8], last11[10:3]};

   logic first_beat, last_beat;
   assign first_beat = (cnt == 8'd0);
   assign last_beat  = (cnt == m_axi_awlen);

   assign m_axi_awid    = AXI_ID;
   assign m_axi_awsize  = 3'b101;
   assign m_axi_awburst = 2'b01;

   // per-lane strobes for the current beat
   logic [LANES-1:0][BE_W-1:0] strb_c;
   always_comb begin
      strb_c = '0;
      for (int i = 0; i < LANES; i++) begin
         if (first_beat && 3'(i) < off)                 strb_c[i] = '0;
         else if (last_beat && 3'(i) > last_lane)       strb_c[i] = '0;
         else if (first_beat && 3'(i) == off)           strb_c[i] = first_be;
         else if (last_beat && 3'(i) == last_lane)      strb_c[i] = len1 ? first_be : last_be;
         else                                           strb_c[i] = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n       = state;
      in_ready      = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wdata   = '0;
      m_axi_wstrb   = '0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      wr_done       = 1'b0;
      wr_err        = 1'b0;
      tlp_drop      = 1'b0;
      case (state)
         S_IDLE: begin
            // sop beat is left pending upstream; DATA consumes it
            if (in_valid) begin
               if (in_sop && is_mwr) begin
                  if (enable) state_n = S_ADDR;
               end else begin
                  state_n = S_DROP;
               end
            end
         end
         S_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_n = S_DATA;
         end
         S_DATA: begin
            in_ready     = m_axi_wready;
            m_axi_wvalid = in_valid;
            m_axi_wdata  = in_data;
            m_axi_wstrb  = strb_c;
            m_axi_wlast  = last_beat;
            if (in_valid && m_axi_wready) begin
               if (last_beat)   state_n = in_eop ? S_RESP : S_TRAIL;
               else if (in_eop) state_n = S_PAD;
            end
         end
         S_PAD: begin
            m_axi_wvalid = 1'b1;
            m_axi_wlast  = last_beat;
            if (m_axi_wready && last_beat) state_n = S_RESP;
         end
         S_TRAIL: begin
            in_ready = 1'b1;
            if (in_valid && in_eop) state_n = S_RESP;
         end
         S_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               wr_done = 1'b1;
               wr_err  = (m_axi_bresp != 2'b00) | err;
               state_n = S_IDLE;
            end
         end
         S_DROP: begin
            in_ready = 1'b1;
            if (in_valid && in_eop) begin
               tlp_drop = 1'b1;
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_axi_awaddr <= '0;
         m_axi_awlen  <= '0;
         cnt          <= '0;
         off          <= '0;
         last_lane    <= '0;
         first_be     <= '0;
         last_be      <= '0;
         len1         <= 1'b0;
         err          <= 1'b0;
      end else begin
         if (state == S_IDLE && state_n == S_ADDR) begin
            m_axi_awaddr <= {in_hdr[63:32], in_hdr[31:5], 5'd0};
            m_axi_awlen  <= awlen11[7:0];
            off          <= in_hdr[4:2];
            last_lane    <= last11[2:0];
            first_be     <= in_hdr[67:64];
            last_be      <= in_hdr[71:68];
            len1         <= (len11 == 11'd1);
         end
         if (state == S_ADDR && m_axi_awready) cnt <= '0;
         if ((state == S_DATA && in_valid && m_axi_wready) || (state == S_PAD && m_axi_wready))
            cnt <= cnt + 8'd1;
         // eop landing anywhere but the final W beat is a length mismatch
         if (state == S_DATA && in_valid && m_axi_wready && (last_beat != in_eop))
            err <= 1'b1;
         if (state == S_RESP && m_axi_bvalid) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tlp_mwr_to_axi.sv
// Directed bench for tlp_mwr_to_axi with scoreboard queues for AW, W and B.
module tb_tlp_mwr_to_axi;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [255:0] in_data;
   logic [127:0] in_hdr;
   logic         in_sop, in_eop, in_valid, in_ready;
   logic [3:0]   m_axi_awid;
   logic [63:0]  m_axi_awaddr;
   logic [7:0]   m_axi_awlen;
   logic [2:0]   m_axi_awsize;
   logic [1:0]   m_axi_awburst;
   logic         m_axi_awvalid, m_axi_awready;
   logic [255:0] m_axi_wdata;
   logic [31:0]  m_axi_wstrb;
   logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [3:0]   m_axi_bid;
   logic [1:0]   m_axi_bresp;
   logic         m_axi_bvalid, m_axi_bready;
   logic         enable, wr_done, wr_err, tlp_drop;

   tlp_mwr_to_axi dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_hdr(in_hdr), .in_sop(in_sop), .in_eop(in_eop),
      .in_valid(in_valid), .in_ready(in_ready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .enable(enable), .wr_done(wr_done), .wr_err(wr_err), .tlp_drop(tlp_drop)
   );

   int vec  = 0;
   int miss = 0;
   int drops = 0;
   logic [1:0] bresp_cfg = 2'b00;

   typedef struct {
      logic [255:0] d;
      logic [31:0]  s;
      logic         l;
   } wexp_t;

   wexp_t      wq[$];
   logic [71:0] awq[$];
   logic       bq[$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] pat(input logic [7:0] s, input int b);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = {s, 8'(b), 8'(i), 8'hA5};
      return r;
   endfunction

   // strobe model indexed by payload DW number k, independent of lane tricks
   function automatic logic [31:0] strb_m(input int off, input int len, input int b,
                                          input logic [3:0] fbe, input logic [3:0] lbe);
      logic [31:0] r;
      int k;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         k = b*8 + i - off;
         if (k < 0 || k >= len) r[i*4 +: 4] = 4'h0;
         else if (k == 0)       r[i*4 +: 4] = fbe;
         else if (k == len-1)   r[i*4 +: 4] = lbe;
         else                   r[i*4 +: 4] = 4'hF;
      end
      return r;
   endfunction

   // scoreboard monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_axi_awvalid && m_axi_awready) begin
            if (awq.size() == 0) chk("aw_unexpected", m_axi_awvalid, 1'b0);
            else begin
               logic [71:0] e;
               e = awq.pop_front();
               chk("awaddr", m_axi_awaddr, e[71:8]);
               chk("awlen", m_axi_awlen, e[7:0]);
               chk("awsize", m_axi_awsize, 3'b101);
               chk("awburst", m_axi_awburst, 2'b01);
               chk("awid", m_axi_awid, 4'h0);
            end
         end
         if (m_axi_wvalid && m_axi_wready) begin
            if (wq.size() == 0) chk("w_unexpected", m_axi_wvalid, 1'b0);
            else begin
               wexp_t w;
               w = wq.pop_front();
               chk("wdata", m_axi_wdata, w.d);
               chk("wstrb", m_axi_wstrb, w.s);
               chk("wlast", m_axi_wlast, w.l);
            end
         end
         if (wr_done) begin
            if (bq.size() == 0) chk("done_unexpected", wr_done, 1'b0);
            else chk("wr_err", wr_err, bq.pop_front());
         end
         if (tlp_drop) drops++;
      end
   end

   // AXI slave B channel: respond one cycle after the wlast handshake
   initial begin
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
      forever begin
         @(negedge clk);
         if (rst_n && m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
            @(posedge clk); #1;
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = bresp_cfg;
            for (int n = 0; n < 200; n++) begin
               @(negedge clk);
               if (m_axi_bready) break;
            end
            @(posedge clk); #1;
            m_axi_bvalid = 1'b0;
            m_axi_bresp  = 2'b00;
         end
      end
   end

   task automatic beat(input logic [255:0] d, input logic s, input logic e, input logic [127:0] h);
      bit got;
      got = 0;
      in_data = d; in_sop = s; in_eop = e; in_hdr = h; in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin got = 1; break; end
      end
      if (!got) chk("beat_timeout", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   function automatic logic [127:0] mk_hdr(input logic [7:0] ft, input logic [63:0] a,
                                           input int len, input logic [3:0] fbe,
                                           input logic [3:0] lbe);
      return {ft, 14'd0, 10'(len), 24'd0, lbe, fbe, a[63:2], 2'b00};
   endfunction

   // eop_at<0: eop on final beat; stop_after>0: send that many beats, no eop, no B
   task automatic run_mwr(input logic [63:0] a, input int len, input logic [3:0] fbe,
                          input logic [3:0] lbe, input int eop_at, input logic [1:0] resp,
                          input int stop_after, input logic [7:0] seed);
      int off, beats, nsend;
      logic [127:0] h;
      wexp_t w;
      off   = int'(a[4:2]);
      beats = (off + len + 7) / 8;
      nsend = (eop_at >= 0) ? eop_at + 1 : beats;
      if (stop_after > 0 && stop_after < nsend) nsend = stop_after;
      bresp_cfg = resp;
      h = mk_hdr(8'h60, a, len, fbe, lbe);
      awq.push_back({a[63:5], 5'd0, 8'(beats - 1)});
      for (int b = 0; b < beats; b++) begin
         if (stop_after > 0 && b >= stop_after) break;
         w.d = (b < nsend) ? pat(seed, b) : '0;
         w.s = (b < nsend) ? strb_m(off, len, b, fbe, lbe) : '0;
         w.l = (b == beats - 1);
         wq.push_back(w);
      end
      if (stop_after == 0) bq.push_back((resp != 2'b00) || (nsend != beats));
      for (int b = 0; b < nsend; b++)
         beat(pat(seed, b), b == 0, (b == nsend - 1) && (stop_after == 0), h);
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (awq.size() == 0 && wq.size() == 0 && bq.size() == 0) break;
      end
      chk(tag, awq.size() + wq.size() + bq.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_hdr = '0;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bid = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awvalid", m_axi_awvalid, 1'b0);
      chk("rst_wvalid", m_axi_wvalid, 1'b0);
      chk("rst_wlast", m_axi_wlast, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_bready", m_axi_bready, 1'b0);
      chk("rst_pulses", {wr_done, wr_err, tlp_drop}, 3'b000);
      chk("rst_awaddr", m_axi_awaddr, 64'd0);
      chk("rst_awlen", m_axi_awlen, 8'd0);
      chk("rst_wstrb", m_axi_wstrb, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // single DW, lane 1
      run_mwr(64'h1000_0004, 1, 4'hF, 4'h0, -1, 2'b00, 0, 8'h11);
      drain("t1_drain");

      // lane 7 start, 3 beats, last BE 3
      run_mwr(64'h2000_001C, 10, 4'hF, 4'h3, -1, 2'b00, 0, 8'h22);
      drain("t2_drain");

      // MRd dropped, then a normal MWr
      beat(pat(8'h33, 0), 1'b1, 1'b0, mk_hdr(8'h20, 64'h3000_0000, 2, 4'hF, 4'hF));
      @(negedge clk);
      chk("drop_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      beat(pat(8'h33, 1), 1'b0, 1'b1, '0);
      @(negedge clk);
      chk("drop_count", drops, 1);
      run_mwr(64'h3000_0100, 8, 4'hF, 4'hF, -1, 2'b00, 0, 8'h34);
      drain("t3_drain");

      // early eop on first beat of a 2-beat burst
      run_mwr(64'h4000_0000, 16, 4'hF, 4'hF, 0, 2'b00, 0, 8'h44);
      drain("t4_drain");

      // slave error response plus W backpressure
      m_axi_wready = 1'b0;
      fork
         run_mwr(64'h5000_0008, 1, 4'h6, 4'h0, -1, 2'b10, 0, 8'h55);
      join_none
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (m_axi_wvalid) break;
      end
      chk("stall_wvalid", m_axi_wvalid, 1'b1);
      for (int n = 0; n < 5; n++) begin
         if (n > 0) @(negedge clk);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_wdata", m_axi_wdata, pat(8'h55, 0));
      end
      @(posedge clk); #1 m_axi_wready = 1'b1;
      wait fork;
      drain("t5_drain");

      // enable=0 holds a pending MWr in IDLE
      enable = 1'b0;
      in_hdr = mk_hdr(8'h60, 64'h6000_0000, 1, 4'hF, 4'h0);
      in_data = pat(8'h66, 0); in_sop = 1'b1; in_eop = 1'b1; in_valid = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk("en0_awvalid", m_axi_awvalid, 1'b0);
         chk("en0_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; enable = 1'b1;
      run_mwr(64'h6000_0000, 1, 4'hF, 4'h0, -1, 2'b00, 0, 8'h66);
      drain("t6_drain");

      // reset in the middle of a 3-beat burst
      run_mwr(64'h7000_0000, 24, 4'hF, 4'hF, -1, 2'b00, 1, 8'h77);
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 4'b0000);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_awlen", m_axi_awlen, 8'd0);
      chk("midrst_queues", awq.size() + wq.size() + bq.size(), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_mwr(64'h7000_0044, 12, 4'h8, 4'h1, -1, 2'b00, 0, 8'h78);
      drain("t7_drain");
      chk("final_drops", drops, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
